// File: rtl/lsu_split.sv
// Load/store unit: turns one B/H/W/D core access into one or two bus-aligned
// memory beats over a req/ack handshake, and extends load data.
module lsu_split #(
    parameter int XLEN             = 64,
    parameter int BUS_W            = 64,
    parameter int ADDR_W           = 64,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [BUS_W-1:0]  mem_wdata,
    output logic [BUS_W/8-1:0] mem_wmask,
    input  logic              mem_ack,
    input  logic [BUS_W-1:0]  mem_rdata
);
    // Handshakes: a request is taken on a clock edge where req_valid && req_ready;
    // a memory beat completes on an edge where mem_req && mem_ack, and mem_*
    // stay frozen until then. resp_valid is a single-cycle pulse, no back-pressure.
    localparam int NB = BUS_W / 8;
    localparam int OB = $clog2(NB);
    localparam int EW = OB + 5;
    localparam int MW = 2 * NB;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state;

    logic              r_wr, r_uns, r_cross;
    logic [1:0]        r_size;
    logic [OB-1:0]     r_off;
    logic [XLEN-1:0]   r_wdata;
    logic [BUS_W-1:0]  beat0;

    logic [OB-1:0]     in_off, sp_off;
    logic [3:0]        in_bytes, sp_bytes;
    logic [EW-1:0]     in_end;
    logic              in_cross, in_bad;
    logic [MW-1:0]     span;
    logic [BUS_W-1:0]  raw0, raw1;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [1:0] size,
                                               input logic uns);
        logic [XLEN-1:0] keep, val;
        logic            sign;
        keep = ~({XLEN{1'b1}} << (8 << size));
        val  = raw & keep;
        sign = |(val & ~(keep >> 1));
        return (sign && !uns) ? (val | ~keep) : val;
    endfunction

    always_comb begin
        in_off   = req_addr[OB-1:0];
        in_bytes = 4'd1 << req_size;
        in_end   = EW'(in_off) + EW'(in_bytes);
        in_cross = in_end > EW'(NB);
        in_bad   = (8 * int'(in_bytes) > XLEN) || (in_cross && (SPLIT_MISALIGNED == 0));
        // One byte-span over two bus words: low half is beat0's mask, high half beat1's.
        sp_off   = (state == IDLE) ? in_off : r_off;
        sp_bytes = (state == IDLE) ? in_bytes : (4'd1 << r_size);
        span     = ((MW'(1) << sp_bytes) - MW'(1)) << sp_off;
        raw0     = mem_rdata >> (8 * int'(r_off));
        raw1     = (beat0 >> (8 * int'(r_off))) | (mem_rdata << (8 * (NB - int'(r_off))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wmask  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r_wr       <= 1'b0;
            r_uns      <= 1'b0;
            r_cross    <= 1'b0;
            r_size     <= '0;
            r_off      <= '0;
            r_wdata    <= '0;
            beat0      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_wr      <= req_wr;
                        r_size    <= req_size;
                        r_uns     <= req_unsigned;
                        r_off     <= in_off;
                        r_cross   <= in_cross;
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (in_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= BEAT0;
                            mem_req   <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
                            mem_we    <= req_wr;
                            mem_wmask <= req_wr ? span[NB-1:0] : '0;
                            mem_wdata <= BUS_W'(req_wdata) << (8 * int'(in_off));
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ack) begin
                        beat0 <= mem_rdata;
                        if (r_cross) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + ADDR_W'(NB);
                            mem_wmask <= r_wr ? span[MW-1:NB] : '0;
                            mem_wdata <= BUS_W'(r_wdata) >> (8 * (NB - int'(r_off)));
                        end else begin
                            state      <= RESP;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_wmask  <= '0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= r_wr ? '0 : extend(XLEN'(raw0), r_size, r_uns);
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wmask  <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= r_wr ? '0 : extend(XLEN'(raw1), r_size, r_uns);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: vector table through a scoreboarded memory responder,
// plus reset-abort, no-split and 32-bit error sequences on extra instances.
module tb_lsu_split;
    localparam logic [63:0] A = 64'h8000_1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_wr, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_req, mem_we, mem_ack;
    logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    lsu_split dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Instance without splitting; its memory acks every beat immediately.
    logic        ns_req_valid, ns_req_ready, ns_resp_valid, ns_resp_err, ns_mem_req, ns_mem_we;
    logic [63:0] ns_resp_rdata, ns_mem_addr, ns_mem_wdata;
    logic [7:0]  ns_mem_wmask;
    logic [63:0] ns_mem_rdata = 64'h0000_0000_1234_5678;

    lsu_split #(.SPLIT_MISALIGNED(0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
        .mem_req(ns_mem_req), .mem_addr(ns_mem_addr), .mem_we(ns_mem_we), .mem_wdata(ns_mem_wdata),
        .mem_wmask(ns_mem_wmask), .mem_ack(ns_mem_req), .mem_rdata(ns_mem_rdata)
    );

    logic        x_req_valid, x_req_ready, x_resp_valid, x_resp_err, x_mem_req, x_mem_we;
    logic [31:0] x_resp_rdata;
    logic [63:0] x_mem_addr, x_mem_wdata;
    logic [7:0]  x_mem_wmask;
    logic        x_mem_ack = 1'b0;

    lsu_split #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .req_valid(x_req_valid), .req_ready(x_req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(x_resp_valid), .resp_rdata(x_resp_rdata), .resp_err(x_resp_err),
        .mem_req(x_mem_req), .mem_addr(x_mem_addr), .mem_we(x_mem_we), .mem_wdata(x_mem_wdata),
        .mem_wmask(x_mem_wmask), .mem_ack(x_mem_ack), .mem_rdata(64'h0)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int resp_edge = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [63:0] bytemask(input logic [7:0] m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    // Scoreboard queues: beats are {addr, we, mask, wdata}, responses {err, rdata}.
    logic [136:0] exp_beat_q[$];
    logic [64:0]  exp_resp_q[$];

    logic [63:0] beat_data[2];
    int          beat_idx = 0;
    int          ack_delay = 0;

    // Memory responder: acks each beat after ack_delay wait cycles and checks it.
    initial begin
        int          wait_cnt;
        logic [63:0] s_addr, s_wdata;
        logic [7:0]  s_mask;
        logic [136:0] e;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!mem_req || rst) begin
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) begin
                    s_addr = mem_addr; s_mask = mem_wmask; s_wdata = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, s_addr);
                    chk("hold_mask", {56'b0, mem_wmask}, {56'b0, s_mask});
                    chk("hold_wdata", mem_wdata, s_wdata);
                end
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = beat_data[beat_idx];
                    if (beat_idx < 1) beat_idx++;
                    wait_cnt  = 0;
                    if (exp_beat_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        e = exp_beat_q.pop_front();
                        chk("beat_addr", mem_addr, e[136:73]);
                        chk("beat_we", {63'b0, mem_we}, {63'b0, e[72]});
                        chk("beat_mask", {56'b0, mem_wmask}, {56'b0, e[71:64]});
                        if (e[72]) chk("beat_wdata", mem_wdata & bytemask(e[71:64]), e[63:0] & bytemask(e[71:64]));
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        logic [64:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (resp_valid && !rst) begin
                resp_edge = edge_cnt;
                chk("ready_in_resp", {63'b0, req_ready}, 64'd0);
                if (exp_resp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    r = exp_resp_q.pop_front();
                    chk("resp_rdata", resp_rdata, r[63:0]);
                    chk("resp_err", {63'b0, resp_err}, {63'b0, r[64]});
                end
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr, wdata, rd0, rd1;
        int          delay, nbeats;
        logic [63:0] a0, w0, a1, w1;
        logic [7:0]  m0, m1;
        logic [63:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rd0, input logic [63:0] rd1,
                                input int delay, input int nbeats,
                                input logic [63:0] a0, input logic [7:0] m0, input logic [63:0] w0,
                                input logic [63:0] a1, input logic [7:0] m1, input logic [63:0] w1,
                                input logic [63:0] exp_rdata);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rd0 = rd0; v.rd1 = rd1; v.delay = delay; v.nbeats = nbeats;
        v.a0 = a0; v.m0 = m0; v.w0 = w0; v.a1 = a1; v.m1 = m1; v.w1 = w1;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, output int acc_edge);
        int bound;
        ack_delay = v.delay;
        beat_data[0] = v.rd0;
        beat_data[1] = v.rd1;
        beat_idx = 0;
        exp_beat_q.push_back({v.a0, v.wr, v.m0, v.w0});
        if (v.nbeats == 2) exp_beat_q.push_back({v.a1, v.wr, v.m1, v.w1});
        exp_resp_q.push_back({1'b0, v.exp_rdata});
        req_wr = v.wr; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        bound = 0;
        while (!req_ready && bound < 20) begin @(posedge clk); #1; bound++; end
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        req_valid = 1'b0;
        bound = 0;
        while (exp_resp_q.size() != 0 && bound < 40) begin @(posedge clk); #1; bound++; end
        if (exp_resp_q.size() != 0) begin
            fail_now("resp_timeout");
            exp_resp_q.delete();
        end
        chk("beats_left", 64'(exp_beat_q.size()), 64'd0);
        exp_beat_q.delete();
        @(posedge clk);
        #1;
        chk("ready_after", {63'b0, req_ready}, 64'd1);
    endtask

    // Drives one request into a side instance and checks it never touches memory.
    task automatic side_err(input bit use32, input logic [1:0] size, input logic [63:0] addr);
        int seen;
        req_wr = 1'b0; req_size = size; req_unsigned = 1'b0; req_addr = addr; req_wdata = '0;
        if (use32) x_req_valid = 1'b1; else ns_req_valid = 1'b1;
        @(posedge clk);
        #1;
        x_req_valid = 1'b0; ns_req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (use32) begin
                chk("x_mem_req", {63'b0, x_mem_req}, 64'd0);
                if (x_resp_valid) begin
                    seen++;
                    chk("x_err", {63'b0, x_resp_err}, 64'd1);
                    chk("x_rdata", {32'b0, x_resp_rdata}, 64'd0);
                end
            end else begin
                chk("ns_mem_req", {63'b0, ns_mem_req}, 64'd0);
                if (ns_resp_valid) begin
                    seen++;
                    chk("ns_err", {63'b0, ns_resp_err}, 64'd1);
                    chk("ns_rdata", ns_resp_rdata, 64'd0);
                end
            end
            @(posedge clk);
            #1;
        end
        chk(use32 ? "x_resp_count" : "ns_resp_count", 64'(seen), 64'd1);
    endtask

    vec_t vecs[15];

    initial begin
        int acc, seen, mreq;
        vecs[0]  = mk(1, 3, 0, A,       64'h1234567887654321, 0, 0, 0, 1, A, 8'hFF, 64'h1234567887654321, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, A+1,     0, 64'h000000000000F080, 0, 0, 1, A, 8'h00, 0, 0, 0, 0, 64'hFFFFFFFFFFFFFFF0);
        vecs[2]  = mk(0, 0, 1, A+1,     0, 64'h000000000000F080, 0, 0, 1, A, 8'h00, 0, 0, 0, 0, 64'h00000000000000F0);
        vecs[3]  = mk(0, 2, 0, A+6,     0, 64'hBBAA000000000000, 64'h000000000000DDCC, 0, 2, A, 8'h00, 0, A+8, 8'h00, 0, 64'hFFFFFFFFDDCCBBAA);
        vecs[4]  = mk(1, 1, 0, A+7,     64'hABCD, 0, 0, 3, 2, A, 8'h80, 64'hCD00000000000000, A+8, 8'h01, 64'hAB, 0);
        vecs[5]  = mk(0, 1, 0, A+2,     0, 64'h0000000087650000, 0, 0, 1, A, 8'h00, 0, 0, 0, 0, 64'hFFFFFFFFFFFF8765);
        vecs[6]  = mk(0, 1, 1, A+2,     0, 64'h0000000087650000, 0, 1, 1, A, 8'h00, 0, 0, 0, 0, 64'h0000000000008765);
        vecs[7]  = mk(0, 2, 0, A+4,     0, 64'h7ABBCCDD00000000, 0, 0, 1, A, 8'h00, 0, 0, 0, 0, 64'h000000007ABBCCDD);
        vecs[8]  = mk(0, 2, 1, A+4,     0, 64'h89ABCDEF00000000, 0, 0, 1, A, 8'h00, 0, 0, 0, 0, 64'h0000000089ABCDEF);
        vecs[9]  = mk(0, 2, 0, A+4,     0, 64'h89ABCDEF00000000, 0, 2, 1, A, 8'h00, 0, 0, 0, 0, 64'hFFFFFFFF89ABCDEF);
        vecs[10] = mk(0, 3, 0, A+3,     0, 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 0, 2, A, 8'h00, 0, A+8, 8'h00, 0, 64'hEEFF001122334455);
        vecs[11] = mk(1, 2, 0, A+14,    64'hDEADBEEF, 0, 0, 1, 2, A+8, 8'hC0, 64'hBEEF000000000000, A+16, 8'h03, 64'hDEAD, 0);
        vecs[12] = mk(0, 1, 0, 64'hFFFFFFFFFFFFFFFF, 0, 64'h5A00000000000000, 64'hA5, 0, 2, 64'hFFFFFFFFFFFFFFF8, 8'h00, 0, 64'h0, 8'h00, 0, 64'hFFFFFFFFFFFFA55A);
        vecs[13] = mk(1, 0, 0, A+5,     64'hFFFFFFFFFFFFFF77, 0, 0, 0, 1, A, 8'h20, 64'h0000770000000000, 0, 0, 0, 0);
        vecs[14] = mk(0, 3, 1, A+8,     0, 64'h8000000000000001, 0, 1, 1, A+8, 8'h00, 0, 0, 0, 0, 64'h8000000000000001);

        rst = 1'b1; req_valid = 1'b0; ns_req_valid = 1'b0; x_req_valid = 1'b0;
        req_wr = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wmask", {56'b0, mem_wmask}, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", {63'b0, req_ready}, 64'd1);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], acc);
            // Accept at edge T, resp_valid raised by edge T+1 (the cycle after mem_req).
            if (i == 0) chk("aligned_latency", 64'(resp_edge - acc), 64'd1);
        end

        // Reset while BEAT0 is waiting for an ack.
        ack_delay = 1000;
        beat_idx = 0;
        req_wr = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = A; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_pre_req", {63'b0, mem_req}, 64'd1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_mem_req", {63'b0, mem_req}, 64'd0);
            chk("abort_resp", {63'b0, resp_valid}, 64'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", {63'b0, req_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle_mem_req", {63'b0, mem_req}, 64'd0);
        ack_delay = 0;

        // No-split instance: misaligned LD errors, aligned LW goes to memory.
        side_err(1'b0, 2'd3, A+4);
        req_size = 2'd2; req_unsigned = 1'b0; req_addr = A; ns_req_valid = 1'b1;
        @(posedge clk);
        #1;
        ns_req_valid = 1'b0;
        seen = 0; mreq = 0;
        for (int i = 0; i < 5; i++) begin
            if (ns_mem_req) mreq++;
            if (ns_resp_valid) begin
                seen++;
                chk("ns_lw_rdata", ns_resp_rdata, 64'h0000000012345678);
                chk("ns_lw_err", {63'b0, ns_resp_err}, 64'd0);
            end
            @(posedge clk);
            #1;
        end
        chk("ns_lw_beats", 64'(mreq), 64'd1);
        chk("ns_lw_resps", 64'(seen), 64'd1);
        chk("ns_ready", {63'b0, ns_req_ready}, 64'd1);

        // 32-bit instance: a doubleword access is rejected.
        side_err(1'b1, 2'd3, A);
        chk("x_ready", {63'b0, x_req_ready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Parameterised load/store unit between the core datapath and the DPI-backed physical memory port.
- Accepts one byte/half/word/double access at a time and generates the bus-aligned address, byte write mask and shifted write data.
- Splits bus-boundary-crossing accesses into two memory beats, and sign- or zero-extends load data.
- Replaces hard-wired single-cycle memory calls with a request/acknowledge handshake.

Parameters:
- XLEN, 64, register/data width in bits (32 or 64).
- BUS_W, 64, memory data bus width in bits; power of two, BUS_W >= XLEN; NB = BUS_W/8.
- ADDR_W, 64, address width.
- SPLIT_MISALIGNED, 1, 1 = boundary-crossing accesses take two beats; 0 = they return an error without a memory access.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  access request
- req_ready  out  1  unit idle, can accept
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  0=B, 1=H, 2=W, 3=D (bytes = 1<<size)
- req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, low bytes significant
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  access rejected
- mem_req  out  1  memory beat request
- mem_addr  out  ADDR_W  NB-aligned beat address
- mem_we  out  1  beat is a write
- mem_wdata  out  BUS_W  lane-shifted write data
- mem_wmask  out  NB  byte enables
- mem_ack  in  1  beat complete; mem_rdata valid this cycle
- mem_rdata  in  BUS_W  read data

Behaviour:
- Clock is clk. Reset rst is synchronous, active-high.
- Reset values: state IDLE, req_ready=1 from the first cycle after reset, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- rst asserted in any state aborts immediately: beat and response discarded, mem_req low the next cycle, no resp_valid.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields. Let o = addr mod NB, n = 1<<size.
  - If n*8 > XLEN, or (o+n > NB and SPLIT_MISALIGNED=0), go to RESP with err=1; no memory access.
  - Otherwise go to BEAT0.
- BEAT0:
  - mem_req=1, mem_addr = addr with low log2(NB) bits cleared, mem_we=req_wr.
  - mem_wmask bits o..min(o+n,NB)-1 set; mem_wdata = wdata << 8*o.
  - For loads mem_wmask=0.
  - Hold all mem_* outputs stable until mem_ack. An ack in the first cycle of mem_req is legal.
  - On ack, capture mem_rdata. Go to BEAT1 if o+n > NB, else RESP.
- BEAT1:
  - mem_addr = BEAT0 address + NB, wrapping modulo 2^ADDR_W.
  - mem_wmask bits 0..(o+n-NB)-1 set; mem_wdata = wdata >> 8*(NB-o).
  - On ack go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Load assembly: raw = (beat0 >> 8*o) | (beat1 << 8*(NB-o)), truncated to n bytes.
  - Sign-extend from bit 8n-1 unless req_unsigned; zero-extend if req_unsigned.
  - D-size on XLEN=64 is not extended.
- Stores: resp_rdata=0. Errors: resp_rdata=0, resp_err=1; resp_err=0 on all successful responses.
- Latency, aligned access with immediate ack: request accepted at edge T, mem_req high during cycle T+1, resp_valid during cycle T+2. A split access adds one cycle per beat plus any ack wait cycles.
- mem_req never asserts in IDLE or RESP.
- mem_ack while mem_req=0 is ignored.
- A new request is accepted only in IDLE. No back-to-back acceptance in the RESP cycle.

Test Plan:
- Reset: hold rst 3 cycles during a pending BEAT0 -> mem_req=0 and resp_valid=0 from the next cycle; req_ready=1 after release.
- Aligned SD: addr 0x80001000, wdata 0x1234567887654321, immediate ack -> one beat, mem_addr 0x80001000, mask 0xFF, resp_valid 2 cycles after accept.
- LB sign/zero: mem_rdata 0x00000000_0000F080, addr 0x80001001 -> LB gives 0xFFFFFFFFFFFFFFF0; LBU gives 0xF0.
- Split LW (BUS_W=64): addr 0x80001006, beat0 rdata 0xBBAA_0000_0000_0000, beat1 rdata 0x0000_0000_0000_DDCC -> beat addresses 0x80001000 then 0x80001008, resp_rdata 0xFFFFFFFFDDCCBBAA.
- Split SH with ack delayed 3 cycles per beat: addr 0x80001007, wdata 0xABCD -> beat0 mask 0x80, wdata byte7=0xCD; beat1 mask 0x01, byte0=0xAB; mem_* stable while waiting.
- SPLIT_MISALIGNED=0, LD at 0x80001004 -> no mem_req, resp_err=1, resp_rdata=0. XLEN=32 with size=3 -> resp_err=1.
